// File: rtl/vga_pixel_sink_if.sv
// Pixel-plot strobe bus and frame-buffer read-back port shared by the plot source and the sink.
// The master drives plots and read requests; the slave returns read data.
interface vga_pixel_sink_if #(
   parameter int unsigned COLOR_W = 24
);
   logic [9:0]         vga_x;
   logic [8:0]         vga_y;
   logic [COLOR_W-1:0] vga_color;
   logic               plot;
   logic               rd_req;
   logic [9:0]         rd_x;
   logic [8:0]         rd_y;
   logic               rd_valid;
   logic [COLOR_W-1:0] rd_color;

   modport master (
      output vga_x, vga_y, vga_color, plot, rd_req, rd_x, rd_y,
      input  rd_valid, rd_color
   );

   modport slave (
      input  vga_x, vga_y, vga_color, plot, rd_req, rd_x, rd_y,
      output rd_valid, rd_color
   );
endinterface

// File: rtl/vga_pixel_sink.sv
// Plot sink: range-checks plot strobes, queues them in a small FIFO and drains them into a frame
// buffer with a registered read-back port. Optional power-on clear is enabled by VGA_SINK_CLEAR_EN.
module vga_pixel_sink #(
   parameter int unsigned XRES       = 160,
   parameter int unsigned YRES       = 120,
   parameter int unsigned COLOR_W    = 24,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned LW         = 4
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   vga_pixel_sink_if.slave     bus,
   output logic                ready,
   output logic                overflow,
   output logic [15:0]         drop_count,
   output logic [15:0]         oob_count,
   output logic [LW-1:0]       fifo_level
);
   localparam int unsigned NPIX = XRES * YRES;
   localparam int unsigned AW   = $clog2(NPIX);
   localparam int unsigned PW   = $clog2(FIFO_DEPTH);

   logic [COLOR_W-1:0] fb_mem     [NPIX];
   logic [AW-1:0]      fifo_addr  [FIFO_DEPTH];
   logic [COLOR_W-1:0] fifo_color [FIFO_DEPTH];

   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]      count_q;
   logic               overflow_q;
   logic [15:0]        drop_q, oob_q;
   logic               rd_valid_q;
   logic [COLOR_W-1:0] rd_color_q;

   logic               in_range, push, pop, drop, oob;
   logic [AW-1:0]      plot_addr;
   logic               rd_fire, rd_in_range;
   logic [AW-1:0]      rd_addr;
   logic               clr_we;
   logic [AW-1:0]      clr_addr;
   logic               mem_we;
   logic [AW-1:0]      mem_waddr;
   logic [COLOR_W-1:0] mem_wdata;

`ifdef VGA_SINK_CLEAR_EN
   typedef enum logic [0:0] {StClear, StRun} state_e;
   state_e        state_q, state_d;
   logic [AW-1:0] clr_addr_q;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StClear;
         clr_addr_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StClear) clr_addr_q <= clr_addr_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StClear: if (clr_addr_q == AW'(NPIX - 1)) state_d = StRun;
         StRun:   state_d = StRun;
      endcase
   end

   always_comb begin
      ready    = (state_q == StRun);
      clr_we   = (state_q == StClear);
      clr_addr = clr_addr_q;
   end
`else
   logic run_q;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) run_q <= 1'b0;
      else         run_q <= 1'b1;
   end

   always_comb begin
      ready    = run_q;
      clr_we   = 1'b0;
      clr_addr = '0;
   end
`endif

   // Upper coordinate bits take part in the compare, so any set high bit is out of range.
   always_comb begin
      in_range  = (bus.vga_x < 10'(XRES)) && (bus.vga_y < 9'(YRES));
      plot_addr = AW'(32'(bus.vga_y) * XRES + 32'(bus.vga_x));
      pop       = ready && (count_q != '0) && !bus.rd_req;
      push      = bus.plot && in_range && ((count_q < LW'(FIFO_DEPTH)) || pop);
      drop      = bus.plot && in_range && !push;
      oob       = bus.plot && !in_range;

      rd_fire     = bus.rd_req && ready;
      rd_in_range = (bus.rd_x < 10'(XRES)) && (bus.rd_y < 9'(YRES));
      rd_addr     = AW'(32'(bus.rd_y) * XRES + 32'(bus.rd_x));
   end

   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         fifo_addr[wr_ptr_q]  <= plot_addr;
         fifo_color[wr_ptr_q] <= bus.vga_color;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         oob_q      <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
         if (drop) overflow_q <= 1'b1;
         if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
         if (oob && (oob_q != 16'hFFFF))   oob_q  <= oob_q + 1'b1;
      end
   end

   // Single-port frame buffer: clear, drain and read never coincide.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = fifo_addr[rd_ptr_q];
      mem_wdata = fifo_color[rd_ptr_q];
      if (clr_we) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end else if (pop) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (mem_we) fb_mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rd_valid_q <= 1'b0;
         rd_color_q <= '0;
      end else begin
         rd_valid_q <= rd_fire;
         if (rd_fire) rd_color_q <= rd_in_range ? fb_mem[rd_addr] : '0;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_color = rd_color_q;
   assign overflow     = overflow_q;
   assign drop_count   = drop_q;
   assign oob_count    = oob_q;
   assign fifo_level   = count_q;
endmodule

// File: tb/tb_vga_pixel_sink.sv
// Randomized and directed bench for vga_pixel_sink against a queue/associative-array pixel model.
// Builds with or without VGA_SINK_CLEAR_EN.
module tb_vga_pixel_sink;
   localparam int unsigned XRES  = 160;
   localparam int unsigned YRES  = 120;
   localparam int unsigned CW    = 24;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LW    = 4;
   localparam int unsigned NPIX  = XRES * YRES;
`ifdef VGA_SINK_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          ready, overflow;
   logic [15:0]   drop_count, oob_count;
   logic [LW-1:0] fifo_level;

   vga_pixel_sink_if #(.COLOR_W(CW)) bus ();

   vga_pixel_sink #(
      .XRES(XRES), .YRES(YRES), .COLOR_W(CW), .FIFO_DEPTH(DEPTH), .LW(LW)
   ) dut (
      .CLOCK_50   (clk),
      .resetn     (resetn),
      .bus        (bus),
      .ready      (ready),
      .overflow   (overflow),
      .drop_count (drop_count),
      .oob_count  (oob_count),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          x;
      int          y;
      logic [23:0] c;
   } pix_t;

   pix_t        q[$];
   logic [23:0] fb[int];
   bit          fb_zero;
   int          m_drop, m_oob;
   bit          m_ovf, m_rdv, m_rdc_known;
   logic [23:0] m_rdc;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int key(input int x, input int y);
      return x * 512 + y;
   endfunction

   function automatic int sat(input int v);
      return (v < 65535) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_drop = 0; m_oob = 0; m_ovf = 0; m_rdv = 0;
      m_rdc = '0; m_rdc_known = 1;
      if (CLEAR_EN) begin
         fb.delete();
         fb_zero = 1;
      end
   endtask

   task automatic drive_idle();
      bus.plot = 0; bus.rd_req = 0;
      bus.vga_x = '0; bus.vga_y = '0; bus.vga_color = '0;
      bus.rd_x = '0; bus.rd_y = '0;
   endtask

   task automatic step(input bit p, input int x, input int y, input logic [23:0] c,
                       input bit rr, input int rx, input int ry);
      int had;
      bit popped;
      @(negedge clk);
      bus.plot = p; bus.vga_x = 10'(x); bus.vga_y = 9'(y); bus.vga_color = c;
      bus.rd_req = rr; bus.rd_x = 10'(rx); bus.rd_y = 9'(ry);
      had = q.size();
      m_rdv = rr;
      if (rr) begin
         if (rx < XRES && ry < YRES) begin
            if (fb.exists(key(rx, ry))) begin m_rdc = fb[key(rx, ry)]; m_rdc_known = 1; end
            else begin m_rdc = '0; m_rdc_known = fb_zero; end
         end else begin
            m_rdc = '0; m_rdc_known = 1;
         end
      end
      popped = 0;
      if (!rr && had > 0) begin
         fb[key(q[0].x, q[0].y)] = q[0].c;
         void'(q.pop_front());
         popped = 1;
      end
      if (p) begin
         if (x >= XRES || y >= YRES) m_oob = sat(m_oob);
         else if (had < DEPTH || popped) q.push_back('{x: x, y: y, c: c});
         else begin m_ovf = 1; m_drop = sat(m_drop); end
      end
      @(posedge clk);
      #1;
      check("fifo_level", 32'(fifo_level), 32'(q.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      check("oob_count", 32'(oob_count), 32'(m_oob));
      check("ready", 32'(ready), 32'd1);
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
      if (m_rdc_known) check("rd_color", 32'(bus.rd_color), 32'(m_rdc));
   endtask

   task automatic idle();
      step(0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic plot1(input int x, input int y, input logic [23:0] c);
      step(1, x, y, c, 0, 0, 0);
   endtask

   task automatic read1(input int x, input int y);
      step(0, 0, 0, '0, 1, x, y);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) idle();
      check("drained", 32'(fifo_level), 32'd0);
   endtask

   task automatic do_reset();
      int n;
      @(negedge clk);
      #2;
      resetn = 0;
      drive_idle();
      #1;
      model_reset();
      check("rst_fifo_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_count), 32'd0);
      check("rst_oob", 32'(oob_count), 32'd0);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("rst_rd_color", 32'(bus.rd_color), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      repeat (2) @(negedge clk);
      resetn = 1;
      #1;
      check("ready_at_release", 32'(ready), 32'd0);
      n = 0;
      while (n < NPIX + 16) begin
         @(posedge clk);
         #1;
         n++;
         if (ready) break;
      end
      check("ready_latency", 32'(n), CLEAR_EN ? 32'(NPIX) : 32'd1);
   endtask

   initial begin
      int rx, ry, px, py;
      fb_zero = 0;
      drive_idle();
      do_reset();

      // Basic plot and read-back.
      plot1(5, 7, 24'hFF0000);
      drain();
      read1(5, 7);
      idle();

      // Corner pixel and out-of-range plot / read.
      plot1(159, 119, 24'h00FF00);
      plot1(160, 0, 24'h123456);
      drain();
      read1(160, 0);
      read1(159, 119);
      idle();

      // Reads hold off the drain: FIFO fills, two plots drop.
      for (int i = 0; i < 10; i++) step(1, 10 + i, 50, 24'h0A0000 + 24'(i), 1, 159, 119);
      check("full_level", 32'(fifo_level), 32'(DEPTH));
      drain();
      for (int i = 0; i < 8; i++) read1(10 + i, 50);
      idle();

      // Same pixel twice keeps the later color.
      plot1(3, 3, 24'h000001);
      plot1(3, 3, 24'h000002);
      drain();
      read1(3, 3);
      idle();

      // Queue four entries, then reset while they are pending.
      step(1, 5, 7, 24'hAAAAAA, 1, 5, 7);
      step(1, 3, 3, 24'hBBBBBB, 1, 5, 7);
      step(1, 159, 119, 24'hCCCCCC, 1, 5, 7);
      step(1, 10, 50, 24'hDDDDDD, 1, 5, 7);
      check("pre_reset_level", 32'(fifo_level), 32'd4);
      do_reset();
      read1(5, 7);
      read1(3, 3);
      read1(159, 119);
      read1(10, 50);
      read1(77, 88);
      idle();

      // Random traffic concentrated on a small window so reads hit written pixels.
      for (int i = 0; i < 400; i++) begin
         px = ($urandom_range(0, 9) == 0) ? int'($urandom_range(150, 170)) : int'($urandom_range(0, 15));
         py = ($urandom_range(0, 9) == 0) ? int'($urandom_range(110, 125)) : int'($urandom_range(0, 15));
         rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(155, 170)) : int'($urandom_range(0, 15));
         ry = int'($urandom_range(0, 15));
         step($urandom_range(0, 9) < 7, px, py, 24'($urandom), $urandom_range(0, 9) < 3, rx, ry);
      end
      drain();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 16; x++) read1(x, y);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
